// File: rtl/iqmap_qpsk.sv
// QPSK mapper: unpacks 128-bit words into 64 two-bit symbols (LSB first) and maps each
// to an (I,Q) coordinate on the axes, with a one-word hold buffer for gapless streaming.
module iqmap_qpsk #(
   parameter logic signed [10:0] AMP = 11'sd512
) (
   input  logic                CLK,
   input  logic                RST,
   input  logic                ce,
   input  logic                valid_i,
   input  logic [127:0]        reader_data,
   output logic                ready_o,
   output logic                valid_o,
   output logic signed [10:0]  ar,
   output logic signed [10:0]  ai,
   output logic [1:0]          raw,
   output logic                last_o
);

   localparam logic signed [10:0] NEG_AMP = -AMP;
   localparam logic signed [10:0] ZERO    = 11'sd0;

   typedef enum logic {S_IDLE, S_ACTIVE} state_t;

   state_t       state_p0, state_nxt;
   logic [127:0] shift_p0;
   logic [127:0] hold_p0;
   logic         hold_full;
   logic [5:0]   cnt_p0;

   logic xfer;
   logic at_end;
   logic ld_shift_in;
   logic ld_shift_hold;
   logic ld_hold;
   logic shift_en;

   function automatic logic [21:0] map_sym(input logic [1:0] s);
      logic [21:0] r;
      case (s)
         2'b00:   r = {AMP, ZERO};
         2'b01:   r = {ZERO, AMP};
         2'b10:   r = {ZERO, NEG_AMP};
         default: r = {NEG_AMP, ZERO};
      endcase
      return r;
   endfunction

   assign ready_o = ~hold_full;
   assign xfer    = ce & valid_i & ~hold_full;
   assign at_end  = (cnt_p0 == 6'd63);

   always_comb begin
      state_nxt     = state_p0;
      ld_shift_in   = 1'b0;
      ld_shift_hold = 1'b0;
      ld_hold       = 1'b0;
      shift_en      = 1'b0;
      case (state_p0)
         S_IDLE: begin
            if (xfer) begin
               ld_shift_in = 1'b1;
               state_nxt   = S_ACTIVE;
            end
         end
         S_ACTIVE: begin
            shift_en = 1'b1;
            // Last symbol of the word: refill from hold, else from the input, else go idle.
            if (at_end) begin
               if (hold_full)
                  ld_shift_hold = 1'b1;
               else if (xfer)
                  ld_shift_in = 1'b1;
               else
                  state_nxt = S_IDLE;
            end else if (xfer) begin
               ld_hold = 1'b1;
            end
         end
         default: state_nxt = S_IDLE;
      endcase
   end

   // Stage p0 -> output: control state and emitted symbol
   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         state_p0  <= S_IDLE;
         hold_full <= 1'b0;
         cnt_p0    <= 6'd0;
         valid_o   <= 1'b0;
         last_o    <= 1'b0;
         ar        <= ZERO;
         ai        <= ZERO;
         raw       <= 2'b00;
      end else if (ce) begin
         state_p0 <= state_nxt;
         valid_o  <= shift_en;
         last_o   <= shift_en & at_end;
         if (shift_en) begin
            raw      <= shift_p0[1:0];
            {ar, ai} <= map_sym(shift_p0[1:0]);
            cnt_p0   <= cnt_p0 + 6'd1;
         end else if (ld_shift_in) begin
            cnt_p0 <= 6'd0;
         end
         if (ld_hold)
            hold_full <= 1'b1;
         else if (ld_shift_hold)
            hold_full <= 1'b0;
      end
   end

   always_ff @(posedge CLK) begin
      if (ce) begin
         if (ld_shift_in)
            shift_p0 <= reader_data;
         else if (ld_shift_hold)
            shift_p0 <= hold_p0;
         else if (shift_en)
            shift_p0 <= {2'b00, shift_p0[127:2]};
         if (ld_hold)
            hold_p0 <= reader_data;
      end
   end

endmodule

// File: tb/tb_iqmap_qpsk.sv
// Directed bench for iqmap_qpsk: single word, back-to-back, boundary load, ce gating,
// reset mid-word, and a loopback through a bench-side demapper.
module tb_iqmap_qpsk;

   localparam int A = 512;

   logic               CLK = 1'b0;
   logic               RST;
   logic               ce;
   logic               valid_i;
   logic [127:0]       reader_data;
   logic               ready_o;
   logic               valid_o;
   logic signed [10:0] ar;
   logic signed [10:0] ai;
   logic [1:0]         raw;
   logic               last_o;

   int n_cmp = 0;
   int n_mis = 0;

   iqmap_qpsk dut (
      .CLK         (CLK),
      .RST         (RST),
      .ce          (ce),
      .valid_i     (valid_i),
      .reader_data (reader_data),
      .ready_o     (ready_o),
      .valid_o     (valid_o),
      .ar          (ar),
      .ai          (ai),
      .raw         (raw),
      .last_o      (last_o)
   );

   always #5 CLK = ~CLK;

   task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_mis++;
         $display("FAIL %s: got %0h want %0h", tag, obs, exp);
      end
   endtask

   function automatic int exp_ar(input logic [1:0] s);
      case (s)
         2'b00:   return A;
         2'b11:   return -A;
         default: return 0;
      endcase
   endfunction

   function automatic int exp_ai(input logic [1:0] s);
      case (s)
         2'b01:   return A;
         2'b10:   return -A;
         default: return 0;
      endcase
   endfunction

   task automatic accept(input logic [127:0] w);
      valid_i     = 1'b1;
      reader_data = w;
      @(posedge CLK); #1;
      valid_i = 1'b0;
   endtask

   // Checks symbols k0..k1 of w; optionally offers word nxt on the edge that emits symbol offer_at.
   task automatic expect_word(input logic [127:0] w, input int k0, input int k1,
                              input int offer_at, input logic [127:0] nxt, input string tag);
      logic [1:0] s;
      logic       rdy;
      for (int k = k0; k <= k1; k++) begin
         if (k == offer_at) begin
            valid_i     = 1'b1;
            reader_data = nxt;
         end
         @(posedge CLK); #1;
         if (k == offer_at) valid_i = 1'b0;
         s   = w[2*k +: 2];
         rdy = !(offer_at >= 0 && offer_at < 63 && k >= offer_at && k < 63);
         chk({tag, "_vld"},  valid_o, 1);
         chk({tag, "_raw"},  raw, s);
         chk({tag, "_ar"},   ar, exp_ar(s));
         chk({tag, "_ai"},   ai, exp_ai(s));
         chk({tag, "_last"}, last_o, (k == 63));
         chk({tag, "_rdy"},  ready_o, rdy);
      end
   endtask

   task automatic idle_check(input logic [127:0] w, input string tag);
      logic [1:0] s;
      s = w[127:126];
      @(posedge CLK); #1;
      chk({tag, "_idle_vld"},  valid_o, 0);
      chk({tag, "_idle_last"}, last_o, 0);
      chk({tag, "_idle_ar"},   ar, exp_ar(s));
      chk({tag, "_idle_raw"},  raw, s);
   endtask

   logic [127:0] words [100];
   logic [127:0] got;
   logic [1:0]   ds;
   logic         ce_edge;
   logic         will_xfer;
   int           sent, recvd, nsym;

   initial begin
      RST         = 1'b0;
      ce          = 1'b0;
      valid_i     = 1'b0;
      reader_data = '0;
      repeat (2) @(posedge CLK);
      #1;
      chk("rst_vld",  valid_o, 0);
      chk("rst_last", last_o, 0);
      chk("rst_ar",   ar, 0);
      chk("rst_ai",   ai, 0);
      chk("rst_raw",  raw, 0);
      chk("rst_rdy",  ready_o, 1);
      RST = 1'b1;
      ce  = 1'b1;
      @(posedge CLK); #1;
      chk("pre_idle_vld", valid_o, 0);

      // Single word 0xE4: symbols 00,01,10,11 then zeros
      accept(128'h0000_0000_0000_0000_0000_0000_0000_00E4);
      expect_word(128'h0000_0000_0000_0000_0000_0000_0000_00E4, 0, 63, -1, '0, "single");
      idle_check(128'h0000_0000_0000_0000_0000_0000_0000_00E4, "single");

      // Back-to-back: second word goes into hold
      accept(128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210);
      expect_word(128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210, 0, 63, 0,
                  128'hA5A5_5A5A_C3C3_3C3C_F0F0_0F0F_9696_6969, "b2b_a");
      expect_word(128'hA5A5_5A5A_C3C3_3C3C_F0F0_0F0F_9696_6969, 0, 63, -1, '0, "b2b_b");
      idle_check(128'hA5A5_5A5A_C3C3_3C3C_F0F0_0F0F_9696_6969, "b2b");

      // Word offered exactly on the last-symbol edge loads directly
      accept(128'h1111_2222_3333_4444_5555_6666_7777_8888);
      expect_word(128'h1111_2222_3333_4444_5555_6666_7777_8888, 0, 63, 63,
                  128'hFEED_FACE_CAFE_BABE_0BAD_F00D_DEAD_BEEF, "bnd_a");
      expect_word(128'hFEED_FACE_CAFE_BABE_0BAD_F00D_DEAD_BEEF, 0, 63, -1, '0, "bnd_b");
      idle_check(128'hFEED_FACE_CAFE_BABE_0BAD_F00D_DEAD_BEEF, "bnd");

      // ce pattern 1,0,0,1 with a word offered while ce is low
      accept(128'hDEAD_BEEF_0123_4567_89AB_CDEF_0F1E_2D3C);
      expect_word(128'hDEAD_BEEF_0123_4567_89AB_CDEF_0F1E_2D3C, 0, 0, -1, '0, "ce");
      ce          = 1'b0;
      valid_i     = 1'b1;
      reader_data = 128'h5555_5555_5555_5555_5555_5555_5555_5555;
      repeat (2) begin
         @(posedge CLK); #1;
         chk("ce_frz_vld", valid_o, 1);
         chk("ce_frz_raw", raw, 2'b00);
         chk("ce_frz_ar",  ar, A);
         chk("ce_frz_rdy", ready_o, 1);
      end
      ce      = 1'b1;
      valid_i = 1'b0;
      expect_word(128'hDEAD_BEEF_0123_4567_89AB_CDEF_0F1E_2D3C, 1, 63, -1, '0, "ce");
      idle_check(128'hDEAD_BEEF_0123_4567_89AB_CDEF_0F1E_2D3C, "ce");

      // Reset at symbol 30 with the hold register full
      accept(128'h0F0F_1E1E_2D2D_3C3C_4B4B_5A5A_6969_7878);
      expect_word(128'h0F0F_1E1E_2D2D_3C3C_4B4B_5A5A_6969_7878, 0, 30, 0,
                  128'h8787_9696_A5A5_B4B4_C3C3_D2D2_E1E1_F0F0, "prerst");
      #2 RST = 1'b0;
      #1;
      chk("mid_rst_vld",  valid_o, 0);
      chk("mid_rst_last", last_o, 0);
      chk("mid_rst_ar",   ar, 0);
      chk("mid_rst_ai",   ai, 0);
      chk("mid_rst_raw",  raw, 0);
      chk("mid_rst_rdy",  ready_o, 1);
      #2 RST = 1'b1;
      accept({128{1'b1}});
      expect_word({128{1'b1}}, 0, 63, -1, '0, "postrst");
      idle_check({128{1'b1}}, "postrst");

      // Loopback through a bench-side demapper with random words and random ce/valid gaps
      foreach (words[i]) words[i] = {$urandom, $urandom, $urandom, $urandom};
      sent        = 0;
      recvd       = 0;
      nsym        = 0;
      got         = '0;
      valid_i     = 1'b1;
      reader_data = words[0];
      for (int cyc = 0; cyc < 20000 && recvd < 100; cyc++) begin
         will_xfer = ce && valid_i && ready_o;
         ce_edge   = ce;
         @(posedge CLK); #1;
         if (ce_edge && valid_o) begin
            if (ar > 0)      ds = 2'b00;
            else if (ai > 0) ds = 2'b01;
            else if (ai < 0) ds = 2'b10;
            else             ds = 2'b11;
            got[2*nsym +: 2] = ds;
            nsym++;
            if (nsym == 64) begin
               chk("loop_word", got, words[recvd]);
               recvd++;
               nsym = 0;
            end
         end
         if (will_xfer) sent++;
         if (sent < 100) reader_data = words[sent];
         valid_i = (sent < 100) && ($urandom_range(0, 3) != 0);
         ce      = ($urandom_range(0, 9) != 0);
      end
      if (recvd < 100) chk("loop_timeout", recvd, 100);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
      $finish;
   end

endmodule

// File: doc/iqmap_qpsk.md
IQMAP_QPSK -- requirements
Module: iqmap_qpsk

Interface
REQ-001 SHALL have parameter AMP, default 11'sd512: signed magnitude of the nonzero constellation coordinate; legal range 1..1023.
REQ-002 SHALL have port CLK, input, 1: the single clock; all state changes on its rising edge.
REQ-003 SHALL have port RST, input, 1: asynchronous, active-low reset.
REQ-004 SHALL have port ce, input, 1: clock enable; when low, all state and outputs hold.
REQ-005 SHALL have port valid_i, input, 1: reader_data is valid.
REQ-006 SHALL have port reader_data, input, 128: 64 packed 2-bit symbols, first-transmitted symbol in bits [1:0].
REQ-007 SHALL have port ready_o, output, 1: the block can accept a word; equals NOT hold_full.
REQ-008 SHALL have port valid_o, output, 1: ar/ai/raw carry a symbol this cycle.
REQ-009 SHALL have port ar, output, signed 11: I coordinate.
REQ-010 SHALL have port ai, output, signed 11: Q coordinate.
REQ-011 SHALL have port raw, output, 2: the 2-bit symbol being emitted.
REQ-012 SHALL have port last_o, output, 1: high together with the 64th symbol of each word.

Function
REQ-013 SHALL transfer a word on a rising CLK edge only when ce && valid_i && ready_o.
REQ-014 SHALL hold a 128-bit shift register, a 128-bit hold register with flag hold_full, a 6-bit symbol counter, and state {s_idle, s_active}.
REQ-015 SHALL, in s_idle on transfer, load the word into the shift register, clear the counter and enter s_active; the hold register stays empty.
REQ-016 SHALL, in s_active on each ce edge, register raw=shift[1:0], map it to ar/ai, set valid_o=1, shift right by 2, and increment the counter.
REQ-017 SHALL map 00->(+AMP,0), 01->(0,+AMP), 10->(0,-AMP), 11->(-AMP,0) for (ar,ai).
REQ-018 SHALL emit the first symbol of a word accepted at edge E0 on ce edge E1, and symbol k on ce edge E(1+k); latency is 1 ce cycle.
REQ-019 SHALL, in s_active with a transfer, write the word into the hold register and set hold_full.
REQ-020 SHALL, on the edge that emits symbol 63 (counter==63), set last_o=1; on every other edge last_o=0.
REQ-021 SHALL, on the counter==63 edge with hold_full, move hold to the shift register, clear hold_full, wrap the counter to 0 and stay in s_active, so that the stream has no gap.
REQ-022 SHALL, on the counter==63 edge with hold empty and a simultaneous transfer, load the incoming word directly into the shift register and stay in s_active, with no gap.
REQ-023 SHALL, on the counter==63 edge with hold empty and no transfer, return to s_idle.
REQ-024 SHALL, on a ce edge in s_idle, drive valid_o=0 and last_o=0, and leave ar, ai and raw at their last values.
REQ-025 SHALL keep ready_o a function of hold_full only, with no combinational path from valid_i.
REQ-026 SHALL, when ce is low, change no register; a transfer cannot occur.

Reset
REQ-027 SHALL, on RST low, immediately force valid_o=0, last_o=0, ar=0, ai=0, raw=0, hold_full=0 (ready_o=1), counter=0 and state=s_idle, regardless of CLK or ce.
REQ-028 SHALL, on reset mid-word, discard the remaining symbols and the held word; the first post-reset transfer starts a fresh word at symbol 0.

Verification
REQ-029 SHALL cover single word: reader_data=128'h...0000_00E4 (symbols 00,01,10,11,...), ce=1 -> edges E1..E4 give (512,0),(0,512),(0,-512),(-512,0); last_o only at E64; valid_o=0 at E65.
REQ-030 SHALL cover back-to-back words: a second word offered during the first -> accepted into hold, ready_o=0 until E64; 128 consecutive valid_o cycles, last_o at E64 and E128.
REQ-031 SHALL cover the simultaneous boundary: hold empty, valid_i first asserted on the E64 edge -> word loads directly; E65 carries its symbol 0 with no gap.
REQ-032 SHALL cover the ce gating pattern 1,0,0,1 during active -> outputs frozen while ce=0; symbol order unbroken; no transfer while ce=0.
REQ-033 SHALL cover reset at symbol 30 with hold full -> outputs 0 and ready_o=1 immediately; a new word of all 11 gives (-512,0) on its E1.
REQ-034 SHALL cover loopback into the QPSK demapper with 100 random words -> demapper writer_data equals the input words in order.
